fhe_instr_sequencer: RTL and testbench
======================================

FHE_INSTR_SEQUENCER -- requirements
Module: fhe_instr_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: instruction queue entries; power of two, at least 2.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: maximum cycles allowed in WAIT before the error trap.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  producer offers in_op this cycle.
REQ-006 in_ready  output  1  queue accepts in_op this cycle.
REQ-007 in_op  input  operation  instruction: mode plus idx1_a/idx1_b/idx2_a/idx2_b/out_a/out_b.
REQ-008 op_out  output  operation  registered instruction presented to the cpu op port.
REQ-009 cpu_done  input  1  cpu done_out; one-cycle pulse marking completion of the held op.
REQ-010 busy  output  1  high in WAIT or GAP.
REQ-011 idle  output  1  high when state is IDLE and the queue is empty.
REQ-012 retired_count  output  16  instructions retired, including NO_OP entries.
REQ-013 timeout_err  output  1  sticky error flag; cleared only by reset.

Function
REQ-014 Push occurs when in_valid && in_ready; in_ready = !full && state != ERROR; in_valid while full is ignored and in_op is not stored.
REQ-015 A simultaneous push and pop while full: the pop completes, the push is refused, and occupancy becomes DEPTH-1.
REQ-016 A pushed entry is visible at the queue head on the next cycle; FIFO order is preserved; pointers wrap modulo FIFO_DEPTH.
REQ-017 The FSM has four states: IDLE, WAIT, GAP, ERROR.
REQ-018 IDLE with an empty queue: hold; op_out.mode = NO_OP.
REQ-019 IDLE with a head entry of mode NO_OP: pop it, increment retired_count, stay in IDLE, op_out unchanged.
REQ-020 IDLE with any other head entry: op_out <= head, wait_cnt <= 0, go to WAIT; the head is not popped yet.
REQ-021 WAIT: op_out is held bit-stable; the cpu re-samples op every cycle, so it must not change.
REQ-022 WAIT with cpu_done: pop, increment retired_count, op_out.mode <= NO_OP (all index fields 0), go to GAP.
REQ-023 WAIT without cpu_done: increment wait_cnt; when wait_cnt == TIMEOUT_CYCLES-1, set op_out to NO_OP, set timeout_err, go to ERROR.
REQ-024 GAP lasts exactly one cycle and then goes to IDLE; it guarantees at least one NO_OP cycle between instructions so the cpu micro-stage counter clears.
REQ-025 ERROR is absorbing until reset; the head entry is neither popped nor retired.
REQ-026 cpu_done outside WAIT is ignored.
REQ-027 retired_count wraps from 0xFFFF to 0.
REQ-028 Issue latency: a push at cycle t into an empty, idle block gives op_out valid at t+2.
REQ-029 Back-to-back: cpu_done at cycle d gives the next op_out at d+3.

Reset
REQ-030 Reset sets: state IDLE; queue empty with pointers 0; op_out all-zero with mode NO_OP; retired_count 0; timeout_err 0; wait_cnt 0.
REQ-031 Reset outputs from the first cycle: in_ready = 1, busy = 0, idle = 1.
REQ-032 Reset asserted mid-WAIT or mid-ERROR discards all queued entries and takes priority over cpu_done and push in the same cycle.

Structure
REQ-033 The operation and op_e types and the NO_OP encoding come from the shared types package; the FSM state enum is local to the module.
REQ-034 The queue is a single sub-module, fhe_op_fifo: synchronous FIFO with a registered count, full, empty, push and pop.
REQ-035 op_out, retired_count and timeout_err are driven directly from flops.

Verification
REQ-036 Push one OP_CT_CT_ADD (out_a=3, out_b=4) at cycle 0 -> op_out mode is OP_CT_CT_ADD at cycle 2; with cpu_done pulsed at cycle 4 -> op_out NO_OP at cycle 5, retired_count=1, idle=1 at cycle 6.
REQ-037 Push 5 ops back-to-back with DEPTH=4 and no cpu_done -> 4 accepted, in_ready=0 from the cycle after the 4th push, 5th op dropped, queue occupancy stays 4.
REQ-038 Queue holds NO_OP, NO_OP, OP_CT_PT_ADD -> the two NO_OPs retire on consecutive cycles, then the add issues; retired_count=2 before any cpu_done.
REQ-039 Issue OP_CT_PT_MUL with TIMEOUT_CYCLES=16 and never pulse cpu_done -> ERROR 16 cycles after issue, timeout_err=1, op_out NO_OP, in_ready=0; a subsequent reset clears everything.
REQ-040 Pulse cpu_done while IDLE, then assert reset during WAIT in the same cycle as cpu_done -> no retire, retired_count=0, queue empty.
REQ-041 Preload retired_count to 0xFFFF via 65535 NO_OP pushes, then retire one more -> retired_count=0.

Source files
------------

// File: rtl/fhe_instr_sequencer_pkg.sv
// Shared operation types for the FHE instruction sequencer and its queue.
package fhe_instr_sequencer_pkg;

    localparam int IDX_W = 8;

    typedef enum logic [2:0] {
        NO_OP        = 3'd0,
        OP_CT_CT_ADD = 3'd1,
        OP_CT_PT_ADD = 3'd2,
        OP_CT_CT_MUL = 3'd3,
        OP_CT_PT_MUL = 3'd4
    } op_e;

    typedef struct packed {
        op_e              mode;
        logic [IDX_W-1:0] idx1_a;
        logic [IDX_W-1:0] idx1_b;
        logic [IDX_W-1:0] idx2_a;
        logic [IDX_W-1:0] idx2_b;
        logic [IDX_W-1:0] out_a;
        logic [IDX_W-1:0] out_b;
    } operation;

    // All-zero operation carrying the NO_OP mode; what the cpu sees between instructions.
    function automatic operation nop_operation();
        operation op_v;
        op_v      = '0;
        op_v.mode = NO_OP;
        return op_v;
    endfunction

endpackage

// File: rtl/fhe_instr_sequencer_fifo.sv
// Synchronous instruction queue with registered occupancy, full and empty.
module fhe_op_fifo
    import fhe_instr_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  logic     pop,
    input  operation wdata,
    output operation rdata,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE    = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    operation         mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic [PTR_W:0]   count_next_s;
    logic             full_r;
    logic             empty_r;
    logic             do_push_s;
    logic             do_pop_s;

    // A push while full is refused even when a pop happens in the same cycle.
    assign do_push_s = push && !full_r;
    assign do_pop_s  = pop && !empty_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign full      = full_r;
    assign empty     = empty_r;

    // Next occupancy from the qualified push/pop pair.
    always_comb begin
        count_next_s = count_r;
        if (do_push_s && !do_pop_s) begin
            count_next_s = count_r + CNT_ONE;
        end else if (!do_push_s && do_pop_s) begin
            count_next_s = count_r - CNT_ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    // Pointer, occupancy and flag registers; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == FULL_COUNT);
            empty_r <= (count_next_s == '0);
        end
    end

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/fhe_instr_sequencer.sv
// Feeds queued FHE operations to the cpu one at a time, holding each until done
// and forcing a NO_OP gap between instructions; traps to ERROR on a stuck cpu.
module fhe_instr_sequencer
    import fhe_instr_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  operation    in_op,
    output operation    op_out,
    input  logic        cpu_done,
    output logic        busy,
    output logic        idle,
    output logic [15:0] retired_count,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_GAP   = 2'd2,
        ST_ERROR = 2'd3
    } state_e;

    localparam int WCNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WCNT_W-1:0] WAIT_ONE  = WCNT_W'(1);

    state_e            state_r;
    state_e            state_next_s;
    operation          op_out_r;
    operation          op_next_s;
    logic [WCNT_W-1:0] wait_cnt_r;
    logic [WCNT_W-1:0] wait_next_s;
    logic [15:0]       retired_r;
    logic [15:0]       retired_next_s;
    logic              err_r;
    logic              err_next_s;
    logic              pop_s;
    logic              push_s;
    logic              q_full_s;
    logic              q_empty_s;
    operation          head_s;

    assign in_ready      = !q_full_s && (state_r != ST_ERROR);
    assign push_s        = in_valid && in_ready;
    assign busy          = (state_r == ST_WAIT) || (state_r == ST_GAP);
    assign idle          = (state_r == ST_IDLE) && q_empty_s;
    assign op_out        = op_out_r;
    assign retired_count = retired_r;
    assign timeout_err   = err_r;

    fhe_op_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (in_op),
        .rdata (head_s),
        .full  (q_full_s),
        .empty (q_empty_s)
    );

    // Next-state and next-output logic; the head is popped only once it retires.
    always_comb begin
        state_next_s   = state_r;
        op_next_s      = op_out_r;
        wait_next_s    = wait_cnt_r;
        retired_next_s = retired_r;
        err_next_s     = err_r;
        pop_s          = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (q_empty_s) begin
                    state_next_s = ST_IDLE;
                end else if (head_s.mode == NO_OP) begin
                    pop_s          = 1'b1;
                    retired_next_s = retired_r + 16'd1;
                end else begin
                    op_next_s    = head_s;
                    wait_next_s  = '0;
                    state_next_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cpu_done) begin
                    pop_s          = 1'b1;
                    retired_next_s = retired_r + 16'd1;
                    op_next_s      = nop_operation();
                    state_next_s   = ST_GAP;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    op_next_s    = nop_operation();
                    err_next_s   = 1'b1;
                    state_next_s = ST_ERROR;
                end else begin
                    wait_next_s = wait_cnt_r + WAIT_ONE;
                end
            end
            ST_GAP: begin
                state_next_s = ST_IDLE;
            end
            ST_ERROR: begin
                state_next_s = ST_ERROR;
            end
            default: begin
                op_next_s    = nop_operation();
                err_next_s   = 1'b1;
                state_next_s = ST_ERROR;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            op_out_r   <= nop_operation();
            wait_cnt_r <= '0;
            retired_r  <= 16'd0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            op_out_r   <= op_next_s;
            wait_cnt_r <= wait_next_s;
            retired_r  <= retired_next_s;
            err_r      <= err_next_s;
        end
    end

endmodule

// File: tb/tb_fhe_instr_sequencer.sv
// Self-checking bench for fhe_instr_sequencer: vector table plus corner-case sequences.
module tb_fhe_instr_sequencer;
    import fhe_instr_sequencer_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    operation    in_op;
    operation    op_out;
    logic        cpu_done;
    logic        busy;
    logic        idle;
    logic [15:0] retired_count;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    operation exp_q[$];
    operation cur_exp;
    logic     prev_nop = 1'b1;
    operation nop_v;

    typedef struct {
        op_e         mode;
        logic [7:0]  oa;
        logic [7:0]  ob;
        int          wait_cyc;
        logic [15:0] exp_ret;
    } vec_t;

    vec_t     vecs[5];
    operation ops[6];
    operation op;

    always #5 clk = ~clk;

    fhe_instr_sequencer #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .op_out        (op_out),
        .cpu_done      (cpu_done),
        .busy          (busy),
        .idle          (idle),
        .retired_count (retired_count),
        .timeout_err   (timeout_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic operation mk(input op_e m, input logic [7:0] oa, input logic [7:0] ob, input int seed);
        operation o;
        o.mode   = m;
        o.idx1_a = 8'(seed + 1);
        o.idx1_b = 8'(seed + 2);
        o.idx2_a = 8'(seed + 3);
        o.idx2_b = 8'(seed + 4);
        o.out_a  = oa;
        o.out_b  = ob;
        return o;
    endfunction

    // One clock cycle of stimulus; accepted non-NO_OP pushes go to the scoreboard.
    task automatic cyc(input logic v, input operation o, input logic done);
        in_valid = v;
        in_op    = o;
        cpu_done = done;
        @(negedge clk);
        if (v && in_ready && !reset && o.mode != NO_OP) exp_q.push_back(o);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cpu_done = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        cpu_done = 1'b0;
        in_op    = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    // Scoreboard: each new instruction on op_out must be the oldest accepted one, held bit-stable.
    always @(negedge clk) begin
        if (reset) begin
            prev_nop = 1'b1;
        end else begin
            if (op_out.mode != NO_OP) begin
                if (prev_nop) begin
                    if (exp_q.size() != 0) cur_exp = exp_q.pop_front();
                    else cur_exp = '0;
                end
                check("sb_op_out", 64'(op_out), 64'(cur_exp));
            end
            prev_nop = (op_out.mode == NO_OP);
        end
    end

    initial begin
        nop_v    = '0;
        reset    = 1'b1;
        in_valid = 1'b0;
        cpu_done = 1'b0;
        in_op    = '0;
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1'b1));
        check("rst_busy", 64'(busy), 64'(1'b0));
        check("rst_idle", 64'(idle), 64'(1'b1));
        check("rst_op_out", 64'(op_out), 64'(nop_v));
        check("rst_retired", 64'(retired_count), 64'(16'd0));
        check("rst_err", 64'(timeout_err), 64'(1'b0));
        do_reset();

        // Single-instruction vectors: latency, hold, done, gap, return to idle.
        vecs[0] = '{OP_CT_CT_ADD, 8'd3,  8'd4,  2,  16'd1};
        vecs[1] = '{OP_CT_PT_ADD, 8'd7,  8'd1,  0,  16'd2};
        vecs[2] = '{OP_CT_CT_MUL, 8'd9,  8'd10, 5,  16'd3};
        vecs[3] = '{OP_CT_PT_MUL, 8'hFF, 8'h80, 1,  16'd4};
        vecs[4] = '{OP_CT_CT_ADD, 8'd0,  8'd5,  14, 16'd5};
        for (int i = 0; i < 5; i++) begin
            op = mk(vecs[i].mode, vecs[i].oa, vecs[i].ob, i * 16);
            cyc(1'b1, op, 1'b0);
            check("vec_t1_nop", 64'(op_out.mode), 64'(NO_OP));
            cyc(1'b0, nop_v, 1'b0);
            check("vec_issue_t2", 64'(op_out), 64'(op));
            repeat (vecs[i].wait_cyc) cyc(1'b0, nop_v, 1'b0);
            check("vec_hold", 64'(op_out), 64'(op));
            check("vec_busy_wait", 64'(busy), 64'(1'b1));
            cyc(1'b0, nop_v, 1'b1);
            check("vec_gap_nop", 64'(op_out), 64'(nop_v));
            check("vec_retired", 64'(retired_count), 64'(vecs[i].exp_ret));
            check("vec_gap_busy", 64'(busy), 64'(1'b1));
            check("vec_gap_idle", 64'(idle), 64'(1'b0));
            cyc(1'b0, nop_v, 1'b0);
            check("vec_back_idle", 64'(idle), 64'(1'b1));
            check("vec_back_busy", 64'(busy), 64'(1'b0));
        end

        // Fill to full, drop overflow, refuse push on simultaneous pop while full.
        do_reset();
        for (int k = 0; k < 6; k++) ops[k] = mk(OP_CT_CT_MUL, 8'(k), 8'(k + 8), k * 5);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, ops[k], 1'b0);
            if (k == 2) check("fill_ready_3", 64'(in_ready), 64'(1'b1));
        end
        check("full_ready", 64'(in_ready), 64'(1'b0));
        cyc(1'b1, ops[4], 1'b0);
        check("full_drop_ready", 64'(in_ready), 64'(1'b0));
        cyc(1'b1, ops[5], 1'b1);
        check("full_pop_push_ready", 64'(in_ready), 64'(1'b1));
        check("full_pop_gap", 64'(op_out), 64'(nop_v));
        cyc(1'b0, nop_v, 1'b0);
        check("b2b_d2_nop", 64'(op_out.mode), 64'(NO_OP));
        cyc(1'b0, nop_v, 1'b0);
        check("b2b_d3_issue", 64'(op_out), 64'(ops[1]));
        for (int j = 0; j < 3; j++) begin
            cyc(1'b0, nop_v, 1'b1);
            cyc(1'b0, nop_v, 1'b0);
            cyc(1'b0, nop_v, 1'b0);
        end
        check("drain_idle", 64'(idle), 64'(1'b1));
        check("drain_retired", 64'(retired_count), 64'(16'd4));
        check("drain_sb_empty", 64'(exp_q.size()), 64'(0));

        // NO_OP entries retire back-to-back before the add issues.
        do_reset();
        op = mk(NO_OP, 8'd1, 8'd2, 40);
        cyc(1'b1, op, 1'b0);
        cyc(1'b1, op, 1'b0);
        check("nop_ret_1", 64'(retired_count), 64'(16'd1));
        op = mk(OP_CT_PT_ADD, 8'd5, 8'd6, 50);
        cyc(1'b1, op, 1'b0);
        check("nop_ret_2", 64'(retired_count), 64'(16'd2));
        check("nop_op_still", 64'(op_out.mode), 64'(NO_OP));
        cyc(1'b0, nop_v, 1'b0);
        check("nop_add_issue", 64'(op_out), 64'(op));
        check("nop_ret_hold", 64'(retired_count), 64'(16'd2));
        cyc(1'b0, nop_v, 1'b1);
        check("nop_add_retire", 64'(retired_count), 64'(16'd3));
        cyc(1'b0, nop_v, 1'b0);

        // Timeout trap, ignored done/push in ERROR, reset recovery.
        do_reset();
        op = mk(OP_CT_PT_MUL, 8'd11, 8'd12, 60);
        cyc(1'b1, op, 1'b0);
        cyc(1'b0, nop_v, 1'b0);
        check("tmo_issue", 64'(op_out), 64'(op));
        repeat (TMO - 1) cyc(1'b0, nop_v, 1'b0);
        check("tmo_pre_err", 64'(timeout_err), 64'(1'b0));
        check("tmo_pre_busy", 64'(busy), 64'(1'b1));
        cyc(1'b0, nop_v, 1'b0);
        check("tmo_err", 64'(timeout_err), 64'(1'b1));
        check("tmo_op_nop", 64'(op_out), 64'(nop_v));
        check("tmo_in_ready", 64'(in_ready), 64'(1'b0));
        check("tmo_busy", 64'(busy), 64'(1'b0));
        check("tmo_idle", 64'(idle), 64'(1'b0));
        cyc(1'b1, mk(OP_CT_CT_ADD, 8'd1, 8'd1, 1), 1'b1);
        check("err_no_retire", 64'(retired_count), 64'(16'd0));
        check("err_sticky", 64'(timeout_err), 64'(1'b1));
        check("err_op_nop", 64'(op_out), 64'(nop_v));
        do_reset();
        check("err_rst_flag", 64'(timeout_err), 64'(1'b0));
        check("err_rst_ready", 64'(in_ready), 64'(1'b1));
        check("err_rst_idle", 64'(idle), 64'(1'b1));

        // cpu_done in IDLE is ignored; reset beats cpu_done and push mid-WAIT.
        do_reset();
        cyc(1'b0, nop_v, 1'b1);
        check("idle_done_ret", 64'(retired_count), 64'(16'd0));
        check("idle_done_idle", 64'(idle), 64'(1'b1));
        cyc(1'b1, mk(OP_CT_CT_ADD, 8'd2, 8'd3, 70), 1'b0);
        cyc(1'b1, mk(OP_CT_PT_ADD, 8'd4, 8'd5, 80), 1'b0);
        check("rstw_in_wait", 64'(busy), 64'(1'b1));
        reset = 1'b1;
        cyc(1'b1, mk(OP_CT_CT_MUL, 8'd6, 8'd7, 90), 1'b1);
        reset = 1'b0;
        exp_q.delete();
        check("rstw_retired", 64'(retired_count), 64'(16'd0));
        check("rstw_op_nop", 64'(op_out), 64'(nop_v));
        repeat (3) cyc(1'b0, nop_v, 1'b0);
        check("rstw_q_empty", 64'(idle), 64'(1'b1));
        check("rstw_op_stay", 64'(op_out), 64'(nop_v));

        // retired_count wraps from 0xFFFF to 0.
        do_reset();
        op = mk(NO_OP, 8'd0, 8'd0, 0);
        for (int n = 0; n < 65535; n++) cyc(1'b1, op, 1'b0);
        cyc(1'b0, nop_v, 1'b0);
        cyc(1'b0, nop_v, 1'b0);
        check("wrap_ffff", 64'(retired_count), 64'(16'hFFFF));
        cyc(1'b1, op, 1'b0);
        cyc(1'b0, nop_v, 1'b0);
        cyc(1'b0, nop_v, 1'b0);
        check("wrap_zero", 64'(retired_count), 64'(16'd0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
